// File: rtl/core_9x8_stack.sv
// rtl/core_9x8_stack.sv - parametrised data stack: T/N registers over a spill memory
module core_9x8_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_clr_err,
  output logic [WIDTH-1:0]       o_top,
  output logic [WIDTH-1:0]       o_next,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int MEM_WORDS = DEPTH - 2;
  localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [WIDTH-1:0]  mem [0:MEM_WORDS-1];
  logic [WIDTH-1:0]  r_top;
  logic [WIDTH-1:0]  r_next;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;

  // Address of the most recently spilled word; meaningful only while count>=3,
  // so it fits the memory address width without a separate "empty" code.
  logic [MEM_AW-1:0] r_mem_addr;
  logic [MEM_AW-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_rd;
  logic              mem_we;

  logic is_empty;
  logic is_full;
  logic ge2;
  logic ge3;
  logic op_push;
  logic op_pop;
  logic op_repl;

  assign is_empty = (r_count == '0);
  assign is_full  = (r_count == CW'(DEPTH));
  assign ge2      = (r_count >= CW'(2));
  assign ge3      = (r_count >= CW'(3));

  assign op_push  = i_push & ~i_pop;
  assign op_pop   = i_pop & ~i_push;
  assign op_repl  = i_push & i_pop;

  assign mem_waddr = ge3 ? (r_mem_addr + MEM_AW'(1)) : '0;
  assign mem_rd    = mem[r_mem_addr];
  assign mem_we    = ~i_rst & op_push & ge2 & ~is_full;

  // Spill storage is never reset; only the pointer and count define validity.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= r_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_top       <= '0;
      r_next      <= '0;
      r_count     <= '0;
      r_mem_addr  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_clr_err) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end

      if (op_push) begin
        if (is_full) begin
          r_overflow <= 1'b1;
        end else begin
          if (ge2) begin
            r_mem_addr <= mem_waddr;
          end
          r_next  <= r_top;
          r_top   <= i_data;
          r_count <= r_count + CW'(1);
        end
      end else if (op_pop) begin
        if (is_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_top <= r_next;
          if (ge3) begin
            r_next     <= mem_rd;
            r_mem_addr <= r_mem_addr - MEM_AW'(1);
          end
          r_count <= r_count - CW'(1);
        end
      end else if (op_repl) begin
        // Replacing on an empty stack degenerates to a push without an error.
        r_top <= i_data;
        if (is_empty) begin
          r_count <= CW'(1);
        end
      end
    end
  end

  assign o_top       = r_top;
  assign o_next      = r_next;
  assign o_count     = r_count;
  assign o_empty     = is_empty;
  assign o_full      = is_full;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_core_9x8_stack.sv
// tb/tb_core_9x8_stack.sv - directed vector bench for core_9x8_stack
module tb_core_9x8_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4, WIDTH=8 instance
  logic       s_rst, s_push, s_pop, s_clr;
  logic [7:0] s_data, s_top, s_next;
  logic [2:0] s_count;
  logic       s_empty, s_full, s_ovf, s_unf;

  // DEPTH=32, WIDTH=9 instance
  logic       w_rst, w_push, w_pop, w_clr;
  logic [8:0] w_data, w_top, w_next;
  logic [5:0] w_count;
  logic       w_empty, w_full, w_ovf, w_unf;

  core_9x8_stack #(.WIDTH(8), .DEPTH(4)) u_small (
    .i_clk(clk), .i_rst(s_rst), .i_push(s_push), .i_pop(s_pop),
    .i_data(s_data), .i_clr_err(s_clr),
    .o_top(s_top), .o_next(s_next), .o_count(s_count),
    .o_empty(s_empty), .o_full(s_full),
    .o_overflow(s_ovf), .o_underflow(s_unf)
  );

  core_9x8_stack #(.WIDTH(9), .DEPTH(32)) u_wide (
    .i_clk(clk), .i_rst(w_rst), .i_push(w_push), .i_pop(w_pop),
    .i_data(w_data), .i_clr_err(w_clr),
    .o_top(w_top), .o_next(w_next), .o_count(w_count),
    .o_empty(w_empty), .o_full(w_full),
    .o_overflow(w_ovf), .o_underflow(w_unf)
  );

  typedef struct {
    logic       push, pop, clr, rst;
    logic [7:0] data;
    int         cnt;
    logic [7:0] t;
    bit         ct;
    logic [7:0] n;
    bit         cn;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic push, input logic pop, input logic clr, input logic rst,
                     input logic [7:0] data, input int cnt,
                     input logic [7:0] t, input bit ct, input logic [7:0] n, input bit cn,
                     input logic ovf, input logic unf);
    vec_t v;
    v.push = push; v.pop = pop; v.clr = clr; v.rst = rst; v.data = data;
    v.cnt = cnt; v.t = t; v.ct = ct; v.n = n; v.cn = cn; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic w_step(input logic push, input logic pop, input logic rst, input logic [8:0] data);
    w_push = push; w_pop = pop; w_rst = rst; w_data = data;
    @(posedge clk);
    @(negedge clk);
    w_push = 1'b0; w_pop = 1'b0; w_rst = 1'b0;
  endtask

  initial begin
    //   push pop clr rst data  cnt  T    ct  N    cn  ovf unf
    add(1, 0, 0, 0, 8'h11, 1, 8'h11, 1, 8'h00, 0, 0, 0);
    add(1, 0, 0, 0, 8'h22, 2, 8'h22, 1, 8'h11, 1, 0, 0);
    add(1, 0, 0, 0, 8'h33, 3, 8'h33, 1, 8'h22, 1, 0, 0);
    add(1, 0, 0, 0, 8'h44, 4, 8'h44, 1, 8'h33, 1, 0, 0);
    add(1, 0, 0, 0, 8'h55, 4, 8'h44, 1, 8'h33, 1, 1, 0);
    add(0, 1, 0, 0, 8'h00, 3, 8'h33, 1, 8'h22, 1, 1, 0);
    add(0, 1, 0, 0, 8'h00, 2, 8'h22, 1, 8'h11, 1, 1, 0);
    add(0, 1, 0, 0, 8'h00, 1, 8'h11, 1, 8'h00, 0, 1, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1);
    add(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 0, 0, 0, 8'h01, 1, 8'h01, 1, 8'h00, 0, 0, 0);
    add(1, 0, 0, 0, 8'h02, 2, 8'h02, 1, 8'h01, 1, 0, 0);
    add(1, 1, 0, 0, 8'hAA, 2, 8'hAA, 1, 8'h01, 1, 0, 0);
    add(0, 1, 0, 0, 8'h00, 1, 8'h01, 1, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 1, 0, 0, 8'h7F, 1, 8'h7F, 1, 8'h00, 0, 0, 0);
    add(0, 0, 0, 0, 8'hE5, 1, 8'h7F, 1, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 0, 0, 0, 8'h5A, 1, 8'h5A, 1, 8'h00, 0, 0, 0);
    add(1, 0, 0, 0, 8'h6B, 2, 8'h6B, 1, 8'h5A, 1, 0, 0);
    add(1, 0, 0, 1, 8'h7C, 0, 8'h00, 1, 8'h00, 1, 0, 0);

    s_rst = 1'b1; s_push = 1'b0; s_pop = 1'b0; s_clr = 1'b0; s_data = '0;
    w_rst = 1'b1; w_push = 1'b0; w_pop = 1'b0; w_clr = 1'b0; w_data = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    s_rst = 1'b0; w_rst = 1'b0;

    chk("rst s_count", 32'(s_count), 0);
    chk("rst s_empty", 32'(s_empty), 1);
    chk("rst s_full",  32'(s_full),  0);
    chk("rst s_top",   32'(s_top),   0);
    chk("rst s_next",  32'(s_next),  0);
    chk("rst s_ovf",   32'(s_ovf),   0);
    chk("rst s_unf",   32'(s_unf),   0);
    chk("rst w_count", 32'(w_count), 0);
    chk("rst w_empty", 32'(w_empty), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      s_push = vecs[i].push; s_pop = vecs[i].pop; s_clr = vecs[i].clr;
      s_rst = vecs[i].rst; s_data = vecs[i].data;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d count", i), 32'(s_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d empty", i), 32'(s_empty), 32'(vecs[i].cnt == 0));
      chk($sformatf("v%0d full",  i), 32'(s_full),  32'(vecs[i].cnt == 4));
      chk($sformatf("v%0d ovf",   i), 32'(s_ovf),   32'(vecs[i].ovf));
      chk($sformatf("v%0d unf",   i), 32'(s_unf),   32'(vecs[i].unf));
      if (vecs[i].ct) chk($sformatf("v%0d top",  i), 32'(s_top),  32'(vecs[i].t));
      if (vecs[i].cn) chk($sformatf("v%0d next", i), 32'(s_next), 32'(vecs[i].n));
    end
    s_push = 1'b0; s_pop = 1'b0; s_clr = 1'b0; s_rst = 1'b0;

    for (int k = 0; k < 32; k++) w_step(1'b1, 1'b0, 1'b0, 9'(9'h100 + k));
    chk("w fill count", 32'(w_count), 32);
    chk("w fill full",  32'(w_full),  1);
    chk("w fill top",   32'(w_top),   32'h11F);
    chk("w fill next",  32'(w_next),  32'h11E);

    w_step(1'b1, 1'b0, 1'b1, 9'h1AA);
    chk("w midrst count", 32'(w_count), 0);
    chk("w midrst top",   32'(w_top),   0);
    chk("w midrst next",  32'(w_next),  0);
    chk("w midrst empty", 32'(w_empty), 1);
    chk("w midrst full",  32'(w_full),  0);
    chk("w midrst ovf",   32'(w_ovf),   0);
    chk("w midrst unf",   32'(w_unf),   0);

    for (int k = 0; k < 32; k++) w_step(1'b1, 1'b0, 1'b0, 9'(9'h100 + k));
    w_step(1'b1, 1'b0, 1'b0, 9'h0AB);
    chk("w ovf count", 32'(w_count), 32);
    chk("w ovf flag",  32'(w_ovf),   1);
    chk("w ovf top",   32'(w_top),   32'h11F);

    for (int k = 0; k < 32; k++) begin
      w_step(1'b0, 1'b1, 1'b0, 9'h000);
      chk($sformatf("w pop%0d count", k), 32'(w_count), 32'(31 - k));
      if (31 - k >= 1) chk($sformatf("w pop%0d top",  k), 32'(w_top),  32'(32'h100 + 30 - k));
      if (31 - k >= 2) chk($sformatf("w pop%0d next", k), 32'(w_next), 32'(32'h100 + 29 - k));
    end
    chk("w drain empty", 32'(w_empty), 1);
    chk("w drain unf",   32'(w_unf),   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_9x8_stack.md
Name: core_9x8_stack

Overview:
- Parametrised data stack for the 9x8 processor core and its peripherals.
- Top-of-stack (T) and next-on-stack (N) are held in registers; deeper entries are held in an asynchronously read memory of DEPTH-2 words.
- Supports push, pop and replace, with occupancy tracking, full/empty status and sticky overflow/underflow error flags.
- Replaces the fixed 8-bit, fixed-depth stack inside the core, so the core can be built at other widths and depths.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 32, total stack capacity including T and N; power of two, >=4.

Ports:
- i_clk  input  1  processor clock; all state changes on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_push  input  1  push i_data.
- i_pop  input  1  pop top entry.
- i_data  input  WIDTH  value for push/replace.
- i_clr_err  input  1  clear sticky error flags.
- o_top  output  WIDTH  T register.
- o_next  output  WIDTH  N register.
- o_count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- o_empty  output  1  o_count==0.
- o_full  output  1  o_count==DEPTH.
- o_overflow  output  1  sticky: push attempted while full.
- o_underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (i_rst high at clock edge):
  - o_top=0, o_next=0, o_count=0, o_overflow=0, o_underflow=0; memory pointer=0.
  - Memory contents are not cleared.
  - Reset overrides every other input in the same cycle, including mid-sequence operations.
- Latency: all outputs are registered and reflect an operation on the cycle after the edge that samples it. o_empty/o_full are decoded from the count register, with no extra latency.
- Operation decode, per cycle:
  - idle (push=0, pop=0): no change.
  - push (push=1, pop=0), count<DEPTH:
    - mem[ptr]<=N (only if count>=2), ptr<=ptr+1 (only if count>=2).
    - N<=T, T<=i_data, count<=count+1.
  - push while count==DEPTH: no data/count/pointer change; o_overflow<=1.
  - pop (push=0, pop=1), count>0:
    - T<=N.
    - N<=mem[ptr-1] and ptr<=ptr-1, both only if count>=3.
    - count<=count-1.
  - pop while count==0: no data/count/pointer change; o_underflow<=1.
  - replace (push=1, pop=1), count>=1: T<=i_data; N, memory, ptr and count unchanged.
  - replace while count==0: behaves as push (T<=i_data, count<=1); no error flag.
- Memory:
  - DEPTH-2 words; write is synchronous; read is combinational from ptr-1, so a pop completes in one cycle.
  - ptr width is log2(DEPTH-2) rounded up. ptr never wraps: guarded by count.
- Validity:
  - o_top is defined only when count>=1; o_next only when count>=2.
  - Stale values in positions above count are unspecified; the bench must not check them.
- Error flags:
  - i_clr_err=1 clears both flags at the edge.
  - If a new error event occurs in the same cycle as i_clr_err, the flag for that event is set (set wins).
  - Flags never clear otherwise except by reset.
- Counting: o_count is an unsigned log2(DEPTH)+1-bit value; it never exceeds DEPTH and never goes below 0.

Test Plan (DEPTH=4, WIDTH=8 unless stated):
- Reset: hold i_rst 5 cycles, then release -> o_count=0, o_empty=1, o_full=0, o_top=0, o_next=0, both flags 0.
- Fill and drain:
  - push 0x11,0x22,0x33,0x44 -> o_count=4, o_full=1, T=0x44, N=0x33.
  - then 4 pops -> T sequence 0x33,0x22,0x11, then o_empty=1.
  - o_next valid values observed: 0x22, 0x11.
- Overflow: from full, push 0x55 -> o_count stays 4, T=0x44, o_overflow=1. A later pop still yields T=0x33.
- Underflow with clear:
  - pop while empty -> o_underflow=1, o_count=0.
  - next cycle, i_clr_err with no op -> o_underflow=0.
  - i_clr_err together with an empty pop -> o_underflow=1.
- Replace:
  - push 0x01, push 0x02, then push+pop with 0xAA -> T=0xAA, N=0x01, o_count=2.
  - replace on an empty stack with 0x7F -> T=0x7F, o_count=1, no flags.
- Mid-operation reset and wide config:
  - WIDTH=9, DEPTH=32: push 32 values 0x100+k, then assert i_rst concurrent with a push -> all outputs 0.
  - Repeat 32 pushes, then 32 pops -> values return LIFO exactly, final o_empty=1.
